// File: rtl/instr_sequencer_if.sv
// Sequencer <-> datapath/decoder bundle: IR and IN-port handshake in,
// phase flag and one-hot instruction strobes out.
interface instr_sequencer_if;
  logic [7:0] ir;
  logic       in_valid;
  logic       in_ack;
  logic       sm;
  logic       mova, movb, movc, movd;
  logic       add, sub, jmp, jg;
  logic       in1, out1, movi, halt;

  modport master (
    input  ir, in_valid,
    output in_ack, sm,
    output mova, movb, movc, movd, add, sub, jmp, jg, in1, out1, movi, halt
  );

  modport slave (
    output ir, in_valid,
    input  in_ack, sm,
    input  mova, movb, movc, movd, add, sub, jmp, jg, in1, out1, movi, halt
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/execute sequencer with IR decode, IN wait and halt.
// Optional single-step PAUSE state is enabled by defining INSTR_SEQ_STEP_EN.
module instr_sequencer #(
  parameter int unsigned ICNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef INSTR_SEQ_STEP_EN
  input  logic              step_mode,
  input  logic              step,
`endif
  instr_sequencer_if.master bus,
  output logic              busy,
  output logic [ICNT_W-1:0] icount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WAIT_IN,
    S_HALTED
`ifdef INSTR_SEQ_STEP_EN
    , S_PAUSE
`endif
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_IN   = 4'h2,
    OP_OUT  = 4'h3,
    OP_MOVA = 4'h4,
    OP_MOVB = 4'h5,
    OP_MOVC = 4'h6,
    OP_MOVD = 4'h7,
    OP_ADD  = 4'h8,
    OP_SUB  = 4'h9,
    OP_MOVI = 4'hA,
    OP_JMP  = 4'hC,
    OP_JG   = 4'hD,
    OP_HALT = 4'hF
  } opcode_e;

  state_e            state_q, state_d;
  logic [ICNT_W-1:0] icount_q, icount_d;
  logic              sm_q, sm_d;
  logic              busy_q, busy_d;
  logic              retire;
  state_e            after_retire;
  logic [3:0]        opcode;

  logic s_mova, s_movb, s_movc, s_movd, s_add, s_sub;
  logic s_jmp, s_jg, s_in1, s_out1, s_movi, s_halt;

  assign opcode = bus.ir[7:4];

`ifdef INSTR_SEQ_STEP_EN
  assign after_retire = step_mode ? S_PAUSE : S_FETCH;
`else
  assign after_retire = S_FETCH;
`endif

  // Strobes are combinational so the decoder sees them in the EXEC cycle itself.
  always_comb begin
    s_mova = 1'b0; s_movb = 1'b0; s_movc = 1'b0; s_movd = 1'b0;
    s_add  = 1'b0; s_sub  = 1'b0; s_jmp  = 1'b0; s_jg   = 1'b0;
    s_in1  = 1'b0; s_out1 = 1'b0; s_movi = 1'b0; s_halt = 1'b0;
    case (state_q)
      S_EXEC: begin
        case (opcode)
          OP_IN:   s_in1  = bus.in_valid;
          OP_OUT:  s_out1 = 1'b1;
          OP_MOVA: s_mova = 1'b1;
          OP_MOVB: s_movb = 1'b1;
          OP_MOVC: s_movc = 1'b1;
          OP_MOVD: s_movd = 1'b1;
          OP_ADD:  s_add  = 1'b1;
          OP_SUB:  s_sub  = 1'b1;
          OP_MOVI: s_movi = 1'b1;
          OP_JMP:  s_jmp  = 1'b1;
          OP_JG:   s_jg   = 1'b1;
          OP_HALT: s_halt = 1'b1;
          default: ;
        endcase
      end
      S_WAIT_IN: s_in1  = bus.in_valid;
      S_HALTED:  s_halt = 1'b1;
      default:   ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    icount_d = icount_q;
    retire   = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        if ((opcode == OP_IN) && !bus.in_valid) begin
          state_d = S_WAIT_IN;
        end else if (opcode == OP_HALT) begin
          state_d = S_HALTED;
          retire  = 1'b1;
        end else begin
          state_d = after_retire;
          retire  = 1'b1;
        end
      end
      S_WAIT_IN: begin
        if (bus.in_valid) begin
          state_d = after_retire;
          retire  = 1'b1;
        end
      end
      S_HALTED: state_d = S_HALTED;
`ifdef INSTR_SEQ_STEP_EN
      S_PAUSE:  if (step) state_d = S_FETCH;
`endif
      default:  state_d = S_IDLE;
    endcase
    if (retire) icount_d = icount_q + ICNT_W'(1);
    // Phase and busy flags are registered, so derive them from the next state.
    sm_d   = (state_d == S_EXEC) || (state_d == S_WAIT_IN) || (state_d == S_HALTED);
    busy_d = (state_d == S_FETCH) || (state_d == S_EXEC) || (state_d == S_WAIT_IN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      icount_q <= '0;
      sm_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      icount_q <= icount_d;
      sm_q     <= sm_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.sm     = sm_q;
  assign bus.mova   = s_mova;
  assign bus.movb   = s_movb;
  assign bus.movc   = s_movc;
  assign bus.movd   = s_movd;
  assign bus.add    = s_add;
  assign bus.sub    = s_sub;
  assign bus.jmp    = s_jmp;
  assign bus.jg     = s_jg;
  assign bus.in1    = s_in1;
  assign bus.out1   = s_out1;
  assign bus.movi   = s_movi;
  assign bus.halt   = s_halt;
  assign bus.in_ack = s_in1;
  assign busy       = busy_q;
  assign icount     = icount_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a cycle-level behavioural model
// compared on every falling edge, plus literal expectations pinning the model.
module tb_instr_sequencer;
  localparam int W = 4;
`ifdef INSTR_SEQ_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, start, step_mode, step, in_valid;
  logic [7:0]   ir;
  logic         busy;
  logic [W-1:0] icount;

  instr_sequencer_if bus();
  assign bus.ir       = ir;
  assign bus.in_valid = in_valid;

  instr_sequencer #(.ICNT_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef INSTR_SEQ_STEP_EN
    .step_mode (step_mode),
    .step      (step),
`endif
    .bus       (bus),
    .busy      (busy),
    .icount    (icount)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Strobe order: mova movb movc movd add sub jmp jg in1 out1 movi halt (bit 11..0)
  logic [11:0] dut_strb;
  assign dut_strb = {bus.mova, bus.movb, bus.movc, bus.movd, bus.add, bus.sub,
                     bus.jmp, bus.jg, bus.in1, bus.out1, bus.movi, bus.halt};

  function automatic logic [11:0] decode(input logic [3:0] op);
    case (op)
      4'h4: return 12'b1000_0000_0000;
      4'h5: return 12'b0100_0000_0000;
      4'h6: return 12'b0010_0000_0000;
      4'h7: return 12'b0001_0000_0000;
      4'h8: return 12'b0000_1000_0000;
      4'h9: return 12'b0000_0100_0000;
      4'hC: return 12'b0000_0010_0000;
      4'hD: return 12'b0000_0001_0000;
      4'h3: return 12'b0000_0000_0100;
      4'hA: return 12'b0000_0000_0010;
      4'hF: return 12'b0000_0000_0001;
      default: return 12'b0;
    endcase
  endfunction

  // Model: started / in execute phase / waiting on input / halted / paused.
  bit m_started, m_in_exec, m_waiting, m_halted, m_paused;
  int m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started <= 1'b0; m_in_exec <= 1'b0; m_waiting <= 1'b0;
      m_halted  <= 1'b0; m_paused  <= 1'b0; m_cnt     <= 0;
    end else if (!m_started) begin
      if (start) m_started <= 1'b1;
    end else if (m_halted) begin
      m_halted <= 1'b1;
    end else if (m_paused) begin
      if (step) m_paused <= 1'b0;
    end else if (!m_in_exec) begin
      m_in_exec <= 1'b1;
    end else if (!m_waiting && ir[7:4] == 4'h2 && !in_valid) begin
      m_waiting <= 1'b1;
    end else if (m_waiting && !in_valid) begin
      m_waiting <= 1'b1;
    end else begin
      m_cnt     <= (m_cnt + 1) % (1 << W);
      m_waiting <= 1'b0;
      if (!m_waiting && ir[7:4] == 4'hF) begin
        m_halted <= 1'b1;
      end else begin
        m_in_exec <= 1'b0;
        m_paused  <= STEP_EN && step_mode;
      end
    end
  end

  always @(negedge clk) begin
    logic [11:0] exp_strb;
    exp_strb = '0;
    if (m_halted) exp_strb[0] = 1'b1;
    else if (m_in_exec && m_waiting) exp_strb[3] = in_valid;
    else if (m_in_exec) begin
      exp_strb = decode(ir[7:4]);
      if (ir[7:4] == 4'h2) exp_strb[3] = in_valid;
    end
    check("model_strobes", int'(dut_strb), int'(exp_strb));
    check("model_in_ack", int'(bus.in_ack), int'(exp_strb[3]));
    check("model_sm", int'(bus.sm), int'(m_halted || m_in_exec));
    check("model_busy", int'(busy), int'(m_started && !m_halted && !m_paused));
    check("model_icount", int'(icount), m_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ops [14];
    ops = '{4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
    rst_n = 1'b0; start = 1'b0; ir = 8'h00; in_valid = 1'b0; step_mode = 1'b0; step = 1'b0;
    tick(); tick();
    check("rst_sm", int'(bus.sm), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_icount", int'(icount), 0);
    check("rst_strobes", int'(dut_strb), 0);

    rst_n = 1'b1; ir = 8'h81;
    tick();
    check("idle_busy", int'(busy), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("add_sm", int'(bus.sm), i % 2);
      check("add_strobe", int'(bus.add), i % 2);
      check("add_busy", int'(busy), 1);
      tick();
    end
    check("add_icount", int'(icount), 3);
    check("add_model_icount", m_cnt, 3);

    ir = 8'h20; in_valid = 1'b0;
    tick();
    check("in_exec_in1", int'(bus.in1), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait_in1", int'(bus.in1), 0);
      check("wait_sm", int'(bus.sm), 1);
      check("wait_icount", int'(icount), 3);
    end
    in_valid = 1'b1;
    #1;
    check("wait_done_in1", int'(bus.in1), 1);
    check("wait_done_ack", int'(bus.in_ack), 1);
    tick();
    check("in_retired_icount", int'(icount), 4);
    check("in_fetch_in1", int'(bus.in1), 0);
    tick();
    check("in_fast_ack", int'(bus.in_ack), 1);
    tick();
    check("in_fast_icount", int'(icount), 5);
    in_valid = 1'b0;

    foreach (ops[k]) begin
      ir = {ops[k], 4'h5};
      tick();
      if (ops[k] == 4'h0 || ops[k] == 4'h1 || ops[k] == 4'hB || ops[k] == 4'hE)
        check("nop_strobes", int'(dut_strb), 0);
      tick();
    end
    check("sweep_icount", int'(icount), 3);

    ir = 8'hF0;
    tick();
    check("halt_exec", int'(bus.halt), 1);
    tick();
    check("halted_icount", int'(icount), 4);
    check("halted_busy", int'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      start = ~start;
      tick();
      check("halted_halt", int'(bus.halt), 1);
      check("halted_sm", int'(bus.sm), 1);
      check("halted_icount_hold", int'(icount), 4);
    end
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check("halt_rst_sm", int'(bus.sm), 0);
    check("halt_rst_halt", int'(bus.halt), 0);
    check("halt_rst_icount", int'(icount), 0);

    tick();
    rst_n = 1'b1; ir = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (34) tick();
    check("wrap_icount", int'(icount), 1);
    check("wrap_sm", int'(bus.sm), 0);

    ir = 8'h20; in_valid = 1'b0;
    tick(); tick(); tick();
    check("midwait_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("midwait_rst_sm", int'(bus.sm), 0);
    check("midwait_rst_busy", int'(busy), 0);
    check("midwait_rst_icount", int'(icount), 0);
    tick();
    rst_n = 1'b1;

`ifdef INSTR_SEQ_STEP_EN
    step_mode = 1'b1; ir = 8'h81; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("step_exec_add", int'(bus.add), 1);
    tick();
    check("pause_sm", int'(bus.sm), 0);
    check("pause_busy", int'(busy), 0);
    check("pause_icount", int'(icount), 1);
    repeat (3) tick();
    check("pause_hold_icount", int'(icount), 1);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("step_fetch_busy", int'(busy), 1);
    tick();
    check("step_exec_sm", int'(bus.sm), 1);
    tick();
    check("step_pause_icount", int'(icount), 2);
    check("step_pause_busy", int'(busy), 0);
    rst_n = 1'b0;
    #1;
    check("pause_rst_icount", int'(icount), 0);
    check("pause_rst_busy", int'(busy), 0);
    tick();
    rst_n = 1'b1;
    step_mode = 1'b0;
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle instruction sequencer for the model computer. It generates the fetch/execute phase flag `sm` and decodes the instruction register into the one-hot instruction strobes (`mova` … `halt`) that the combinational control-signal decoder consumes. It also handles start-up, the IN-port wait handshake and the halt state, and counts retired instructions. It sits between the IR and the control-signal decoder; the datapath is unchanged.

## Interface
- `ICNT_W`, 16, width of the retired-instruction counter
- `clk`  in  1  system clock, all state changes on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  level; leaves IDLE when high
- `ir`  in  8  instruction register contents; opcode = `ir[7:4]`, valid in any cycle following FETCH
- `in_valid`  in  1  input port holds valid data
- `step_mode`  in  1  (only with `INSTR_SEQ_STEP_EN`) pause after each instruction
- `step`  in  1  (only with `INSTR_SEQ_STEP_EN`) one-cycle pulse that releases PAUSE
- `sm`  out  1  0 = fetch phase, 1 = execute phase
- `mova, movb, movc, movd, add, sub, jmp, jg, in1, out1, movi, halt`  out  1 each  one-hot instruction strobes
- `in_ack`  out  1  input data consumed this cycle
- `busy`  out  1  high in FETCH/EXEC/WAIT_IN
- `icount`  out  `ICNT_W`  retired-instruction count

## Operation
- Opcode map (`ir[7:4]`):
  - 0x0 NOP, 0x2 IN, 0x3 OUT, 0x4 MOVA, 0x5 MOVB, 0x6 MOVC, 0x7 MOVD, 0x8 ADD, 0x9 SUB, 0xA MOVI, 0xC JMP, 0xD JG, 0xF HALT.
  - Every other opcode executes as NOP: no strobe, retires normally.
- States: IDLE, FETCH, EXEC, WAIT_IN, HALTED, plus PAUSE when the macro is defined.
- Transitions:
  - IDLE → FETCH when `start`=1.
  - FETCH → EXEC always.
  - EXEC:
    - IN with `in_valid`=0 → WAIT_IN.
    - HALT → HALTED.
    - Otherwise → FETCH, or → PAUSE when the macro is defined and `step_mode`=1.
  - WAIT_IN → FETCH (or PAUSE) when `in_valid`=1.
  - PAUSE → FETCH when `step`=1.
  - HALTED is left only by reset.
- `sm`: 0 in IDLE, FETCH and PAUSE; 1 in EXEC, WAIT_IN and HALTED.
- Strobes are combinational from state and `ir`, and are all 0 outside EXEC, except:
  - EXEC: exactly the decoded strobe is 1 (none for NOP/illegal), except IN, where `in1` = `in_valid`.
  - WAIT_IN: only `in1` = `in_valid`; all other strobes 0.
  - HALTED: `halt`=1 continuously, so downstream `sm_en` stays 0.
- `in_ack` = `in1`. Input data is written exactly once per IN instruction.
- `icount`:
  - Increments by 1 on the cycle an instruction retires: EXEC leaving to FETCH/PAUSE/HALTED, or WAIT_IN completing.
  - Wraps 2^ICNT_W−1 → 0.
  - HALT counts once.
- `start` is ignored outside IDLE. `step` is ignored outside PAUSE.

## Timing
- Reset (asynchronous, any state, including mid-WAIT_IN): state = IDLE, `sm`=0, all strobes 0, `in_ack`=0, `busy`=0, `icount`=0.
- Release of `rst_n` takes effect synchronously. The first FETCH occurs the cycle after `start` is sampled high.
- Normal instruction: 2 cycles (FETCH, EXEC).
- IN: 2 cycles if `in_valid` is high in EXEC; otherwise 2 + N cycles, where N is the number of WAIT_IN cycles up to and including the one with `in_valid`=1.
- `in_valid` and `start` are both sampled at the rising edge, with no extra latency.
- Step mode: PAUSE lasts until `step` is seen. FETCH follows in the next cycle.
- If `step_mode` changes mid-instruction, it is sampled only at the retire edge.

## Configuration
- `INSTR_SEQ_STEP_EN` defined:
  - Ports `step_mode` and `step` exist, and the PAUSE state is implemented.
  - With `step_mode`=1, the sequencer halts in PAUSE (`sm`=0, `busy`=0) after every retired instruction.
- `INSTR_SEQ_STEP_EN` undefined:
  - Ports and the PAUSE state are absent.
  - Execution is continuous FETCH/EXEC.

## Test plan
- Reset, then `start`=1 with `ir`=0x81 (ADD).
  - Expect `sm` 0,1,0,1…; `add`=1 only in EXEC cycles.
  - `icount` reaches 3 after 6 cycles.
- `ir`=0x20 (IN), `in_valid`=0 for 3 cycles, then 1.
  - Expect 3 WAIT_IN cycles with `in1`=0, then exactly one cycle with `in1`=`in_ack`=1.
  - `icount`+1 only at completion.
- `ir`=0xF0 (HALT).
  - Expect `halt`=1 and `sm`=1 permanently; `start` toggling has no effect.
  - `icount` increments exactly once.
  - `rst_n` low → IDLE, `icount`=0.
- Illegal opcodes 0x1, 0xB, 0xE.
  - Expect no strobe high; each retires in 2 cycles.
- `icount` preloaded near wrap (ICNT_W=4, run 17 instructions).
  - Expect `icount`=1.
- With `INSTR_SEQ_STEP_EN`, `step_mode`=1.
  - After each EXEC: PAUSE with `sm`=0, `busy`=0.
  - A single `step` pulse yields exactly one FETCH+EXEC.
  - `rst_n` asserted during PAUSE → IDLE.
